// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers and default Q-format parameters for the adder
// datapath and its requantiser.
package fxp_pkg;

    localparam int FXP_N_IN  = 6;
    localparam int FXP_M_IN  = 12;
    localparam int FXP_N_OUT = 4;
    localparam int FXP_M_OUT = 8;
    localparam int FXP_CNT_W = 16;

    // Total width of a Q(n.m) value, sign bit included in n.
    function automatic int fxp_w(input int n, input int m);
        return n + m;
    endfunction

    // Largest positive value representable in a w-bit two's complement word.
    function automatic longint fxp_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Most negative value representable in a w-bit two's complement word.
    function automatic longint fxp_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Half of the LSB that survives a right shift by d (0 when nothing is dropped).
    function automatic longint fxp_half(input int d);
        if (d <= 0) return 0;
        return longint'(1) <<< (d - 1);
    endfunction

endpackage

// File: rtl/fxp_sat_clamp.sv
// Combinational signed clamp of an IN_W-bit value into OUT_W bits.
// o_sat flags that the input lay outside the output range.
module fxp_sat_clamp
    import fxp_pkg::*;
#(
    parameter int IN_W  = 19,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    localparam logic signed [IN_W-1:0] MAXV = IN_W'(fxp_max(OUT_W));
    localparam logic signed [IN_W-1:0] MINV = IN_W'(fxp_min(OUT_W));

    // Pass in-range values through, pin out-of-range values to the rails.
    always_comb begin
        o_sat  = 1'b0;
        o_data = i_data[OUT_W-1:0];
        if (i_data > MAXV) begin
            o_data = MAXV[OUT_W-1:0];
            o_sat  = 1'b1;
        end else if (i_data < MINV) begin
            o_data = MINV[OUT_W-1:0];
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_requant_pipe.sv
// Two-stage valid/ready requantiser Q(N_IN.M_IN) -> Q(N_OUT.M_OUT).
// Stage 1: adder-overflow saturation, then round/truncate and shift.
// Stage 2: range clamp. Counts delivered saturated samples in sat_cnt.
// Build option: FXP_ROUND_EN selects round-half-up; otherwise truncation (floor).
module fxp_requant_pipe
    import fxp_pkg::*;
#(
    parameter int N_IN  = FXP_N_IN,
    parameter int M_IN  = FXP_M_IN,
    parameter int N_OUT = FXP_N_OUT,
    parameter int M_OUT = FXP_M_OUT,
    parameter int CNT_W = FXP_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [fxp_w(N_IN,M_IN)-1:0]  in_data,
    input  logic                         in_ovf,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [fxp_w(N_OUT,M_OUT)-1:0] out_data,
    output logic                         out_sat,
    input  logic                         clr_cnt,
    output logic [CNT_W-1:0]             sat_cnt
);

    localparam int W_IN  = fxp_w(N_IN, M_IN);
    localparam int W_OUT = fxp_w(N_OUT, M_OUT);
    localparam int D     = M_IN - M_OUT;
    // One guard bit over the input absorbs the rounding carry.
    localparam int W_S   = (W_IN + 1 > W_OUT) ? W_IN + 1 : W_OUT;

`ifdef FXP_ROUND_EN
    localparam logic signed [W_S-1:0] RND = W_S'(fxp_half(D));
`else
    localparam logic signed [W_S-1:0] RND = '0;
`endif
    localparam logic signed [W_S-1:0] S_MAX = W_S'(fxp_max(W_OUT));
    localparam logic signed [W_S-1:0] S_MIN = W_S'(fxp_min(W_OUT));

    generate
        if (M_OUT > M_IN) begin : g_bad_frac
            $error("fxp_requant_pipe: M_OUT must not exceed M_IN");
        end
    endgenerate

    logic                    r_s1_valid, r_s1_sat;
    logic signed [W_S-1:0]   r_s1_data;
    logic                    r_out_valid, r_out_sat;
    logic [W_OUT-1:0]        r_out_data;
    logic [CNT_W-1:0]        r_sat_cnt;

    logic                    w_s1_adv;
    logic signed [W_S-1:0]   w_ext, w_s1_d;
    logic signed [W_OUT-1:0] w_cl_d;
    logic                    w_cl_sat;
    logic                    w_sat_hs;

    assign w_s1_adv = !r_out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s1_adv;

    // Stage-1 arithmetic: an adder overflow inverts the apparent sign, so the
    // MSB picks the opposite rail; otherwise round (optional) and shift down.
    always_comb begin
        w_ext  = W_S'($signed(in_data));
        w_s1_d = (w_ext + RND) >>> D;
        if (in_ovf) begin
            w_s1_d = in_data[W_IN-1] ? S_MAX : S_MIN;
        end
    end

    // Stage-1 register: load whenever the slot is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sat   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= w_s1_d;
                r_s1_sat  <= in_ovf;
            end
        end
    end

    fxp_sat_clamp #(
        .IN_W  (W_S),
        .OUT_W (W_OUT)
    ) u_clamp (
        .i_data (r_s1_data),
        .o_data (w_cl_d),
        .o_sat  (w_cl_sat)
    );

    // Output register: holds its sample while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_cl_d;
                r_out_sat  <= r_s1_sat || w_cl_sat;
            end
        end
    end

    assign w_sat_hs = r_out_valid && out_ready && r_out_sat;

    // Saturating event counter; clear takes priority over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (clr_cnt) begin
            r_sat_cnt <= '0;
        end else if (w_sat_hs && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_fxp_requant_pipe.sv
// Scoreboard bench for fxp_requant_pipe at default parameters (out 12b).
module tb_fxp_requant_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_data = '0;
    logic        in_ovf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_data;
    logic        out_sat;
    logic        clr_cnt = 1'b0;
    logic [15:0] sat_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [12:0] sb[$];   // {sat, data}

`ifdef FXP_ROUND_EN
    localparam int RND_T = 8;
`else
    localparam int RND_T = 0;
`endif

    fxp_requant_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .clr_cnt   (clr_cnt),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: floor((v + half)/16) then clamp to [-2048, 2047].
    function automatic logic [12:0] model(input logic [17:0] d, input bit ovf);
        int v, q;
        if (ovf) return d[17] ? 13'h17FF : 13'h1800;
        v = int'($signed(d)) + RND_T;
        q = v / 16;
        if ((v % 16) != 0 && v < 0) q = q - 1;
        if (q > 2047) return 13'h17FF;
        if (q < -2048) return 13'h1800;
        return {1'b0, q[11:0]};
    endfunction

    task automatic drive_cycle(input logic [17:0] d, input bit ovf, input logic [12:0] e,
                               output bit acc);
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = ovf;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        if (acc) sb.push_back(e);
        #1;
    endtask

    task automatic send(input logic [17:0] d, input bit ovf, input logic [12:0] e);
        bit acc = 1'b0;
        for (int k = 0; k < 64 && !acc; k++) drive_cycle(d, ovf, e, acc);
        if (!acc) chk("send_accept", {31'b0, acc}, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks that a
    // stalled sample does not change until it is taken.
    initial begin
        logic [12:0] e;
        bit          hold_pend = 1'b0;
        logic [11:0] hold_d = '0;
        logic        hold_s = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_data", {20'b0, out_data}, {20'b0, hold_d});
                    chk("hold_sat", {31'b0, out_sat}, {31'b0, hold_s});
                end
                hold_pend = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", {31'b0, out_valid}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", {20'b0, out_data}, {20'b0, e[11:0]});
                        chk("out_sat", {31'b0, out_sat}, {31'b0, e[12]});
                    end
                end else if (out_valid) begin
                    hold_pend = 1'b1;
                    hold_d    = out_data;
                    hold_s    = out_sat;
                end
            end
        end
    end

    initial begin
        logic [17:0] stall_d[4];
        logic [17:0] bnd[6];
        int          idx;
        bit          acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid2", {31'b0, out_valid}, 0);
        chk("rst_out_data", {20'b0, out_data}, 0);
        chk("rst_out_sat", {31'b0, out_sat}, 0);
        chk("rst_sat_cnt", {16'b0, sat_cnt}, 0);
        @(posedge clk);
        #1;

        // 1: 1.5 passes through, two-cycle latency
        send(18'h01800, 1'b0, 13'h0180);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1", {31'b0, out_valid}, 0);
        @(negedge clk);
        chk("lat_c2", {31'b0, out_valid}, 1);
        drain();

        // 2: sub-LSB values, rounding vs truncation
`ifdef FXP_ROUND_EN
        send(18'h00008, 1'b0, 13'h0001);
        send(18'h3FFF8, 1'b0, 13'h0000);
`else
        send(18'h00008, 1'b0, 13'h0000);
        send(18'h3FFF8, 1'b0, 13'h0FFF);
`endif
        in_valid = 1'b0;
        drain();

        // 3: range clamp both rails, counter
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        send(18'h0A000, 1'b0, 13'h17FF);
        send(18'h36000, 1'b0, 13'h1800);
        in_valid = 1'b0;
        drain();
        chk("sat_cnt_2", {16'b0, sat_cnt}, 2);

        // 4: adder overflow inverts sign
        send(18'h20000, 1'b1, 13'h17FF);
        send(18'h1FFFF, 1'b1, 13'h1800);
        in_valid = 1'b0;
        drain();
        chk("sat_cnt_4", {16'b0, sat_cnt}, 4);

        // Boundaries around the rails, then random traffic
        bnd = '{18'h07FF8, 18'h07FF7, 18'h38000, 18'h37FFF, 18'h1FFFF, 18'h20000};
        foreach (bnd[i]) send(bnd[i], 1'b0, model(bnd[i], 1'b0));
        for (int i = 0; i < 40; i++) begin
            logic [17:0] d;
            bit          o;
            d = 18'($urandom_range(0, 18'h3FFFF));
            o = ($urandom_range(0, 7) == 0);
            send(d, o, model(d, o));
        end
        in_valid = 1'b0;
        drain();

        // 5: downstream stall, only two samples fit
        stall_d = '{18'h00100, 18'h00200, 18'h3FF00, 18'h0A000};
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(stall_d[idx], 1'b0, model(stall_d[idx], 1'b0), acc);
            if (acc) idx++;
        end
        chk("stall_accepted", idx, 2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        while (idx < 4) begin
            send(stall_d[idx], 1'b0, model(stall_d[idx], 1'b0));
            idx++;
        end
        in_valid = 1'b0;
        drain();

        // 6: counter saturates and holds, clear beats increment
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        for (int i = 0; i < 65540; i++) send(18'h0A000, 1'b0, 13'h17FF);
        in_valid = 1'b0;
        drain();
        chk("sat_cnt_hold", {16'b0, sat_cnt}, 32'hFFFF);
        send(18'h36000, 1'b0, 13'h1800);
        in_valid = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            acc = out_valid;
        end
        chk("clr_wait_valid", {31'b0, acc}, 1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_wins", {16'b0, sat_cnt}, 0);

        // Reset mid-stream discards in-flight samples
        send(18'h00400, 1'b0, model(18'h00400, 1'b0));
        send(18'h00800, 1'b0, model(18'h00800, 1'b0));
        send(18'h00C00, 1'b0, model(18'h00C00, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        in_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_stale", {31'b0, out_valid}, 0);
        end
        chk("midrst_in_ready", {31'b0, in_ready}, 1);

        // Pipe still works after the reset
        send(18'h01800, 1'b0, 13'h0180);
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
